// File: rtl/mcdf_fifo_pkg.sv
// Shared constants and default-threshold helpers for the MCDF channel FIFO.
// Imported by the FIFO top level and its storage sub-module.
package mcdf_fifo_pkg;

    localparam int unsigned MCDF_FIFO_AW   = 6;
    localparam int unsigned MCDF_FIFO_DW   = 32;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Nominal margin of 4 entries, shrunk for tiny FIFOs so the level checks still hold.
    function automatic int unsigned mcdf_fifo_af_level(input int unsigned aw);
        int unsigned depth;
        depth = 32'd1 << aw;
        return (depth > 4) ? depth - 4 : depth;
    endfunction

    function automatic int unsigned mcdf_fifo_ae_level(input int unsigned aw);
        int unsigned depth;
        depth = 32'd1 << aw;
        return (depth > 4) ? 4 : depth - 1;
    endfunction

endpackage

// File: rtl/mcdf_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Contents are not reset; the pointers in the top level guard reachability.
module mcdf_fifo_mem
    import mcdf_fifo_pkg::*;
#(
    parameter int unsigned AW = MCDF_FIFO_AW,
    parameter int unsigned DW = MCDF_FIFO_DW
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mcdf_sync_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module mcdf_sync_fifo
    import mcdf_fifo_pkg::*;
#(
    parameter int unsigned AW       = MCDF_FIFO_AW,
    parameter int unsigned DW       = MCDF_FIFO_DW,
    parameter int unsigned FWFT     = FIFO_MODE_STD,
    parameter int unsigned AF_LEVEL = mcdf_fifo_af_level(AW),
    parameter int unsigned AE_LEVEL = mcdf_fifo_ae_level(AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_full,
    output logic          wr_almost_full,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_valid,
    output logic          rd_empty,
    output logic          rd_almost_empty,
    output logic [AW:0]   fifo_count,
    output logic [AW:0]   fifo_margin,
    input  logic          err_clr,
    output logic          ovf_err,
    output logic          udf_err
);

    localparam int unsigned DEPTH = 2**AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT    = (AW+1)'(AE_LEVEL);

    if (AF_LEVEL > DEPTH) begin : g_af_level_chk
        $error("mcdf_sync_fifo: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_ae_level_chk
        $error("mcdf_sync_fifo: AE_LEVEL must be below DEPTH");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc, rd_acc;
    logic [DW-1:0] mem_rd_data;

    assign rd_acc = rd_en & ~rd_empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign wr_acc = wr_en & (~wr_full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + (AW)'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + (AW)'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // A new error event takes priority over a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_en & ~wr_acc) begin
            ovf_d = 1'b1;
        end
        if (rd_en & rd_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    mcdf_fifo_mem #(
        .AW (AW),
        .DW (DW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data_i),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    if (FWFT == FIFO_MODE_STD) begin : g_std_read
        logic [DW-1:0] rd_data_q;
        logic          rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                if (rd_acc) begin
                    rd_data_q <= mem_rd_data;
                end
                rd_valid_q <= rd_acc;
            end
        end

        assign rd_data_o = rd_data_q;
        assign rd_valid  = rd_valid_q;
    end else begin : g_fwft_read
        assign rd_data_o = rd_empty ? '0 : mem_rd_data;
        assign rd_valid  = ~rd_empty;
    end

    assign fifo_count      = count_q;
    assign fifo_margin     = DEPTH_CNT - count_q;
    assign wr_full         = (count_q == DEPTH_CNT);
    assign rd_empty        = (count_q == '0);
    assign wr_almost_full  = (count_q >= AF_CNT);
    assign rd_almost_empty = (count_q <= AE_CNT);
    assign ovf_err         = ovf_q;
    assign udf_err         = udf_q;

endmodule
